// File: rtl/macpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and default
// bus widths used by the controller, fetch unit and decoder.
package macpu_pkg;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_LOCKED = 2'd2
    } fetch_state_t;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 64;
    localparam int DEF_INSTR_BYTES = 8;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch unit bus bundle: memory req/ack channel plus decoder
// valid/ready channel. master = fetch unit, slave = memory/decoder.
interface pc_fetch_unit_if
    import macpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_data,
        output instr, instr_valid,
        input  instr_ready
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_data,
        input  instr, instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/pc_reg.sv
// Program counter register: reset, load and wrapping increment.
// Ports: clk, rst, i_set/i_set_addr (load), i_inc (step),
// o_pc (current), o_pc_next (value after this edge).
module pc_reg #(
    parameter int                ADDR_W       = 32,
    parameter int                INSTR_BYTES  = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_next
);
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_next;

    // Load beats increment; the add wraps modulo 2^ADDR_W.
    always_comb begin
        w_next = r_pc;
        if (i_set)
            w_next = i_set_addr;
        else if (i_inc)
            w_next = r_pc + ADDR_W'(INSTR_BYTES);
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_pc <= RESET_VECTOR;
        else
            r_pc <= w_next;
    end

    assign o_pc      = r_pc;
    assign o_pc_next = w_next;
endmodule

// File: rtl/pc_fetch_unit.sv
// PC holder and instruction fetch sequencer (FETCH/HOLD/LOCKED).
// Ports: clk, rst (sync, active-high); controller strobes
// i_pc_set_enable, i_set_address, i_pc_address_enable, i_pc_lock;
// o_address; bus (memory + decoder handshakes).
// Optional PC_MISALIGN_CHECK_EN: adds o_misalign and rejects
// misaligned set targets instead of truncating them.
module pc_fetch_unit
    import macpu_pkg::*;
#(
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter int                DATA_W       = DEF_DATA_W,
    parameter int                INSTR_BYTES  = DEF_INSTR_BYTES,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pc_set_enable,
    input  logic [ADDR_W-1:0] i_set_address,
    input  logic              i_pc_address_enable,
    input  logic              i_pc_lock,
    output logic [ADDR_W-1:0] o_address,
`ifdef PC_MISALIGN_CHECK_EN
    output logic              o_misalign,
`endif
    pc_fetch_unit_if.master   bus
);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(INSTR_BYTES - 1);

    fetch_state_t      r_state;
    logic              r_flush;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic [DATA_W-1:0] r_instr;

    logic              w_set;
    logic [ADDR_W-1:0] w_set_addr;
    logic              w_inc;
    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pc_next;

`ifdef PC_MISALIGN_CHECK_EN
    logic w_misalign;
    logic r_misalign;

    assign w_misalign = i_pc_set_enable &&
                        ((i_set_address & OFF_MASK) != '0);
    assign w_set      = i_pc_set_enable && !w_misalign;
    assign w_set_addr = i_set_address;

    always_ff @(posedge clk) begin
        if (rst)
            r_misalign <= 1'b0;
        else
            r_misalign <= w_misalign;
    end

    assign o_misalign = r_misalign;
`else
    assign w_set      = i_pc_set_enable;
    assign w_set_addr = i_set_address & ~OFF_MASK;
`endif

    // Only a clean ack (no pending or same-cycle redirect) advances PC.
    assign w_inc = (r_state == S_FETCH) && bus.mem_ack &&
                   !r_flush && !w_set;

    pc_reg #(
        .ADDR_W       (ADDR_W),
        .INSTR_BYTES  (INSTR_BYTES),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .i_set      (w_set),
        .i_set_addr (w_set_addr),
        .i_inc      (w_inc),
        .o_pc       (w_pc),
        .o_pc_next  (w_pc_next)
    );

    // r_fetch_addr is captured from the post-edge PC whenever a new
    // request starts, so it stays stable while the request is up.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_flush      <= 1'b0;
            r_fetch_addr <= RESET_VECTOR;
            r_instr      <= '0;
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        if (r_flush || w_set) begin
                            r_flush      <= 1'b0;
                            r_fetch_addr <= w_pc_next;
                        end else begin
                            r_instr <= bus.mem_data;
                            r_state <= S_HOLD;
                        end
                    end else if (w_set) begin
                        r_flush <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_set || bus.instr_ready) begin
                        if (i_pc_lock) begin
                            r_state <= S_LOCKED;
                        end else begin
                            r_state      <= S_FETCH;
                            r_fetch_addr <= w_pc_next;
                        end
                    end
                end
                S_LOCKED: begin
                    if (!i_pc_lock) begin
                        r_state      <= S_FETCH;
                        r_fetch_addr <= w_pc_next;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign bus.mem_req     = (r_state == S_FETCH);
    assign bus.mem_addr    = r_fetch_addr;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = (r_state == S_HOLD);

    assign o_address = i_pc_address_enable ? w_pc : '0;
endmodule
